memory_stage: RTL

//  RV32I memory-access stage between execute (M-stage signals) and writeback.
//  - Drives a req/ready data-memory bus; stalls the pipe while memory is pending.
//  - Aligns store data and byte enables; sign/zero-extends load data.
//  - Holds the MEM/WB pipeline register that feeds the writeback mux.

---
 rtl/memory_stage_if.sv | 30 +++
 rtl/memory_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// -----------------------------------------------------------------------------
// memory_stage_if
// Data-memory request/ready bus between the memory stage and data memory.
//   dmem_req    master->slave  access request (held until dmem_ready)
//   dmem_we     master->slave  1 = write, 0 = read
//   dmem_addr   master->slave  word-aligned byte address
//   dmem_wdata  master->slave  lane-replicated store data
//   dmem_be     master->slave  byte enables
//   dmem_rdata  slave->master  read data, valid with dmem_ready
//   dmem_ready  slave->master  access completes this cycle
// -----------------------------------------------------------------------------
interface memory_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// RV32I memory-access stage between execute (M signals) and writeback.
// Issues loads/stores on a req/ready bus, stalls the pipe while the access is
// pending, aborts after TIMEOUT_CYCLES, aligns store data / byte enables,
// extends load data and holds the MEM/WB pipeline register.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   RegWriteM..PCPlus4M M-stage control and data inputs
//   bus                 data-memory bus (memory_stage_if.master)
//   stall_mem           hold F/D/E/M this cycle
//   bus_err             one-cycle pulse when an access is aborted
//   RegWriteW..PCPlus4W MEM/WB register outputs
//
// Build option: define MEM_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses (no request, bus_err pulse, write-back suppressed). Without it,
// misaligned accesses are issued with the low address bits ignored as needed.
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteM,
  input  logic                 MemReadM,
  input  logic                 MemWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [2:0]           funct3M,
  input  logic [4:0]           RdM,
  input  logic [31:0]          ALU_ResultM,
  input  logic [31:0]          WriteDataM,
  input  logic [31:0]          PCPlus4M,
  memory_stage_if.master       bus,
  output logic                 stall_mem,
  output logic                 bus_err,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [4:0]           RdW,
  output logic [31:0]          ALU_ResultW,
  output logic [31:0]          ReadDataW,
  output logic [31:0]          PCPlus4W
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // Access size encoding
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] wcnt_r, wcnt_s;

  logic       mem_op_s;
  logic [1:0] size_s;
  logic [1:0] off_s;
  logic       misalign_s;
  logic       issue_s;
  logic       abort_s;

  // Unsigned-load variants (LBU/LHU) only exist for reads; any other
  // unrecognised funct3 falls back to a full word.
  function automatic logic [1:0] decode_size(input logic is_load, input logic [2:0] f3);
    logic [1:0] sz;
    case (f3)
      3'b000:  sz = SZ_BYTE;
      3'b001:  sz = SZ_HALF;
      3'b100:  sz = is_load ? SZ_BYTE : SZ_WORD;
      3'b101:  sz = is_load ? SZ_HALF : SZ_WORD;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] a, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[8*a +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (sz)
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign mem_op_s = MemReadM | MemWriteM;
  assign size_s   = decode_size(MemReadM, funct3M);
  assign off_s    = ALU_ResultM[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_s = mem_op_s & (((size_s == SZ_HALF) & off_s[0]) |
                                  ((size_s == SZ_WORD) & (off_s != 2'b00)));
`else
  assign misalign_s = 1'b0;
`endif

  // Gating with rst makes the request drop as soon as reset asserts.
  assign issue_s   = mem_op_s & ~misalign_s & rst;
  // Counter reaches its last value on the final permitted wait cycle.
  assign abort_s   = issue_s & (state_r == S_WAIT) & ~bus.dmem_ready & (wcnt_r >= LAST_WAIT);
  assign stall_mem = issue_s & ~bus.dmem_ready & ~abort_s;
  assign bus_err   = abort_s | (misalign_s & rst);

  assign bus.dmem_req   = issue_s;
  assign bus.dmem_we    = issue_s & MemWriteM;
  assign bus.dmem_addr  = {ALU_ResultM[31:2], 2'b00};
  assign bus.dmem_be    = issue_s ? lane_be(size_s, off_s) : 4'b0000;
  assign bus.dmem_wdata = lane_wdata(size_s, WriteDataM);

  // FSM state and wait-counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      wcnt_r  <= '0;
    end else begin
      state_r <= state_s;
      wcnt_r  <= wcnt_s;
    end
  end

  // FSM next state and wait-counter update
  always_comb begin
    state_s = state_r;
    wcnt_s  = wcnt_r;
    case (state_r)
      S_IDLE: begin
        if (issue_s && !bus.dmem_ready) begin
          state_s = S_WAIT;
          wcnt_s  = CNT_W'(1);
        end else begin
          state_s = S_IDLE;
          wcnt_s  = '0;
        end
      end
      S_WAIT: begin
        if (!issue_s || bus.dmem_ready || abort_s) begin
          state_s = S_IDLE;
          wcnt_s  = '0;
        end else begin
          state_s = S_WAIT;
          wcnt_s  = wcnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        wcnt_s  = '0;
      end
    endcase
  end

  // MEM/WB pipeline register: bubble while stalled, otherwise capture M stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RdW         <= 5'd0;
      ALU_ResultW <= 32'd0;
      ReadDataW   <= 32'd0;
      PCPlus4W    <= 32'd0;
    end else if (stall_mem) begin
      RegWriteW   <= 1'b0;
    end else begin
      // Aborted or rejected accesses retire without writing a register.
      RegWriteW   <= RegWriteM & ~abort_s & ~misalign_s;
      ResultSrcW  <= ResultSrcM;
      RdW         <= RdM;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= (MemReadM & issue_s & bus.dmem_ready)
                     ? load_ext(size_s, funct3M[2], off_s, bus.dmem_rdata) : 32'd0;
      PCPlus4W    <= PCPlus4M;
    end
  end

endmodule
